// File: rtl/int_fp_donusum_pipe.sv
// rtl/int_fp_donusum_pipe.sv - multi-cycle integer to floating-point converter
//
// Converts a signed or unsigned IW-bit integer to a {sign, EW exponent, MW mantissa}
// floating-point value. One operation in flight; sequence IDLE-ABS-LZC-NORM-RND-DONE.
// Optional build macro: INT_FP_RNE_EN (defined: round to nearest even, else truncate).
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   valid_i/ready_o       operand handshake (ready_o high only in IDLE)
//   data_i, signed_i      integer operand and its signedness
//   valid_o/ready_i       result handshake (valid_o high only in DONE)
//   data_o, inexact_o     converted value and inexact flag, stable while in DONE
module int_fp_donusum_pipe #(
    parameter int IW = 32,
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IW-1:0]    data_i,
    input  logic             signed_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [EW+MW:0]   data_o,
    output logic             inexact_o
);
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int PW   = (IW > 1) ? $clog2(IW) : 1;
    // Normalized magnitude without its hidden bit, padded so mantissa, guard
    // and sticky slices exist even when IW-1 <= MW.
    localparam int XW   = IW + MW + 1;

    // IW <= BIAS keeps bias+IW (worst case after round-up carry) below the
    // all-ones exponent, so no overflow handling is needed.
    if (IW > BIAS) begin : g_cfg_check
        $error("int_fp_donusum_pipe: IW must not exceed the exponent bias");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_LZC,
        S_NORM,
        S_RND,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [IW-1:0]    data_r;
    logic             signed_r;
    logic             sign_r;
    logic [IW-1:0]    mag_r;
    logic [PW-1:0]    lead_r;
    logic             zero_r;
    logic [EW-1:0]    exp_r;

    logic             neg;
    logic [PW-1:0]    lzc_p;
    logic [PW-1:0]    shamt;
    logic [XW-1:0]    ext;
    logic [MW-1:0]    mant;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [EW+MW-1:0] rounded;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (valid_i) state_next = S_ABS;
            S_ABS:   state_next = S_LZC;
            S_LZC:   state_next = S_NORM;
            S_NORM:  state_next = S_RND;
            S_RND:   state_next = S_DONE;
            S_DONE:  if (ready_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign ready_o = (state == S_IDLE);
    assign valid_o = (state == S_DONE);

    assign neg = signed_r & data_r[IW-1];

    // Highest set bit wins; the loop walks upward so the last hit is the leader.
    always_comb begin
        lzc_p = '0;
        for (int i = 0; i < IW; i++) begin
            if (mag_r[i]) lzc_p = i[PW-1:0];
        end
    end

    assign shamt = PW'(IW - 1) - lead_r;

    assign ext    = {mag_r[IW-2:0], {(MW + 2){1'b0}}};
    assign mant   = ext[XW-1 -: MW];
    assign guard  = ext[XW-1-MW];
    assign sticky = |ext[XW-2-MW:0];

`ifdef INT_FP_RNE_EN
    assign round_up = guard & (sticky | mant[0]);
`else
    assign round_up = 1'b0;
`endif

    // Adding across the exponent/mantissa boundary makes a mantissa carry
    // clear the mantissa and bump the exponent in one step.
    assign rounded = {exp_r, mant} + {{(EW + MW - 1){1'b0}}, round_up};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_r    <= '0;
            signed_r  <= 1'b0;
            sign_r    <= 1'b0;
            mag_r     <= '0;
            lead_r    <= '0;
            zero_r    <= 1'b0;
            exp_r     <= '0;
            data_o    <= '0;
            inexact_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        data_r   <= data_i;
                        signed_r <= signed_i;
                    end
                end
                S_ABS: begin
                    sign_r <= neg;
                    mag_r  <= neg ? -data_r : data_r;
                end
                S_LZC: begin
                    lead_r <= lzc_p;
                    zero_r <= (mag_r == '0);
                end
                S_NORM: begin
                    mag_r <= mag_r << shamt;
                    exp_r <= EW'(BIAS) + EW'(lead_r);
                end
                S_RND: begin
                    if (zero_r) begin
                        data_o    <= '0;
                        inexact_o <= 1'b0;
                    end else begin
                        data_o    <= {sign_r, rounded};
                        inexact_o <= guard | sticky;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_fp_donusum_pipe.sv
// tb/tb_int_fp_donusum_pipe.sv - randomized self-checking bench for int_fp_donusum_pipe
module tb_int_fp_donusum_pipe;
    localparam int IW = 32;
    localparam int EW = 8;
    localparam int MW = 23;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic        signed_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        inexact_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    int_fp_donusum_pipe #(.IW(IW), .EW(EW), .MW(MW)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .signed_i  (signed_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .inexact_o (inexact_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value-level reference: exponent = floor(log2|x|), mantissa = |x| scaled to
    // MW fraction bits, rounding decided by comparing the discarded remainder
    // against half an ulp. Returns {inexact, sign, exponent, mantissa}.
    function automatic logic [32:0] model(input logic [31:0] d, input logic s);
        logic            ng;
        logic            inx;
        longint unsigned mag, q, rem, half;
        int              e, sh;
        ng  = s && d[31];
        mag = ng ? ((64'd1 << 32) - {32'd0, d}) : {32'd0, d};
        inx = 1'b0;
        if (mag == 0) return 33'd0;
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        if (e <= MW) begin
            q = mag << (MW - e);
        end else begin
            sh   = e - MW;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 0);
`ifdef INT_FP_RNE_EN
            if (rem > half || (rem == half && q[0])) q++;
            if ((q >> (MW + 1)) != 0) begin
                q = q >> 1;
                e++;
            end
`endif
        end
        return {inx, ng, 8'(e + 127), q[22:0]};
    endfunction

    // One full transaction from an IDLE negedge back to the next IDLE negedge.
    task automatic conv(input string tag, input logic [31:0] d, input logic s,
                        input int stall, input logic [31:0] exp_d, input logic exp_x);
        int lat;
        check({tag, "_ready_idle"}, ready_o, 1);
        valid_i  = 1'b1;
        data_i   = d;
        signed_i = s;
        ready_i  = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!valid_o && lat < 20) begin
            check({tag, "_ready_busy"}, ready_o, 0);
            valid_i = 1'($urandom);
            data_i  = $urandom;
            @(negedge clk);
            lat++;
        end
        valid_i = 1'b0;
        check({tag, "_latency"}, lat, 4);
        check({tag, "_data"}, data_o, exp_d);
        check({tag, "_inexact"}, inexact_o, exp_x);
        for (int k = 0; k < stall; k++) begin
            valid_i = 1'($urandom);
            data_i  = $urandom;
            @(negedge clk);
            check({tag, "_hold_valid"}, valid_o, 1);
            check({tag, "_hold_ready"}, ready_o, 0);
            check({tag, "_hold_data"}, data_o, exp_d);
            check({tag, "_hold_inexact"}, inexact_o, exp_x);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check({tag, "_back_ready"}, ready_o, 1);
        check({tag, "_back_valid"}, valid_o, 0);
    endtask

    task automatic conv_rand(input string tag, input logic [31:0] d, input logic s, input int stall);
        logic [32:0] m;
        m = model(d, s);
        conv(tag, d, s, stall, m[31:0], m[32]);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the summary line");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          sel;
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        data_i   = '0;
        signed_i = 1'b0;
        ready_i  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_inexact", inexact_o, 0);
        rst_i = 1'b0;
        @(negedge clk);

        conv("one",      32'h00000001, 1'b1, 0,  32'h3F800000, 1'b0);
        conv("minus1",   32'hFFFFFFFF, 1'b1, 1,  32'hBF800000, 1'b0);
        conv("zero",     32'h00000000, 1'b1, 0,  32'h00000000, 1'b0);
        conv("mneg_s",   32'h80000000, 1'b1, 0,  32'hCF000000, 1'b0);
        conv("mneg_u",   32'h80000000, 1'b0, 10, 32'h4F000000, 1'b0);
        conv("tie_even", 32'h01000001, 1'b0, 0,  32'h4B800000, 1'b1);
`ifdef INT_FP_RNE_EN
        conv("rnd_up",   32'h01000003, 1'b0, 0,  32'h4B800002, 1'b1);
        conv("carry",    32'hFFFFFFFF, 1'b0, 2,  32'h4F800000, 1'b1);
`else
        conv("trunc",    32'h01000003, 1'b0, 0,  32'h4B800001, 1'b1);
        conv("trunc_ff", 32'hFFFFFFFF, 1'b0, 2,  32'h4F7FFFFF, 1'b1);
`endif

        // Asynchronous reset landing in NORM: two edges after the accept edge.
        valid_i  = 1'b1;
        data_i   = 32'h12345678;
        signed_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        check("arst_data", data_o, 0);
        check("arst_inexact", inexact_o, 0);
        check("arst_valid", valid_o, 0);
        check("arst_ready", ready_o, 1);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        check("arst_ready_after", ready_o, 1);
        conv("five", 32'h00000005, 1'b0, 0, 32'h40A00000, 1'b0);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       d = $urandom;
                1:       d = $urandom >> $urandom_range(0, 31);
                2:       d = (32'd1 << $urandom_range(0, 31)) | 32'($urandom_range(0, 3));
                default: d = $urandom | 32'hFF000000;
            endcase
            conv_rand("rand", d, 1'($urandom), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
